// File: rtl/fifo_out_write_ctrl.sv
// Write-side controller for the 32-entry output FIFO register file: one-hot write enables,
// head pointer for the read mux, occupancy flags and a 32-cycle clear sweep.
module fifo_out_write_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [DATA_W-1:0]     din,
  input  logic                  rd_en,
  input  logic                  clear,
  output logic [(2**ADDR_W)-1:0] we,
  output logic [DATA_W-1:0]     wdata,
  output logic [ADDR_W-1:0]     rd_addr,
  output logic [ADDR_W:0]       count,
  output logic                  full,
  output logic                  empty,
  output logic                  busy,
  output logic                  ovf,
  output logic                  udf
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [DEPTH-1:0]  ONE_HOT   = {{(DEPTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_FULL  = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t             state_r, state_nx_s;
  logic [ADDR_W-1:0]  wr_ptr_r, wr_ptr_nx_s;
  logic [ADDR_W-1:0]  rd_ptr_r, rd_ptr_nx_s;
  logic [ADDR_W-1:0]  clr_idx_r, clr_idx_nx_s;
  logic [ADDR_W:0]    count_r, count_nx_s;
  logic               full_r, empty_r, busy_r, ovf_r, udf_r;
  logic               busy_nx_s, ovf_nx_s, udf_nx_s;
  logic               push_ok_s, pop_ok_s;
  logic [DEPTH-1:0]   we_s;
  logic [DATA_W-1:0]  wdata_s;

  assign push_ok_s = wr_en & ~full_r & ~busy_r;
  assign pop_ok_s  = rd_en & ~empty_r & ~busy_r;

  // Next-state, pointer/occupancy update and register-file write port decode
  always_comb begin
    state_nx_s   = state_r;
    wr_ptr_nx_s  = wr_ptr_r;
    rd_ptr_nx_s  = rd_ptr_r;
    clr_idx_nx_s = clr_idx_r;
    count_nx_s   = count_r;
    busy_nx_s    = busy_r;
    ovf_nx_s     = 1'b0;
    udf_nx_s     = 1'b0;
    we_s         = '0;
    wdata_s      = din;
    case (state_r)
      IDLE: begin
        if (clear) begin
          // Requests coinciding with clear are dropped silently
          state_nx_s   = CLEAR;
          wr_ptr_nx_s  = '0;
          rd_ptr_nx_s  = '0;
          clr_idx_nx_s = '0;
          count_nx_s   = '0;
          busy_nx_s    = 1'b1;
        end else begin
          we_s        = push_ok_s ? (ONE_HOT << wr_ptr_r) : '0;
          wr_ptr_nx_s = push_ok_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
          rd_ptr_nx_s = pop_ok_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
          ovf_nx_s    = wr_en & ~push_ok_s;
          udf_nx_s    = rd_en & ~pop_ok_s;
          case ({push_ok_s, pop_ok_s})
            2'b10:   count_nx_s = count_r + CNT_ONE;
            2'b01:   count_nx_s = count_r - CNT_ONE;
            default: count_nx_s = count_r;
          endcase
        end
      end
      CLEAR: begin
        we_s         = ONE_HOT << clr_idx_r;
        wdata_s      = '0;
        clr_idx_nx_s = clr_idx_r + PTR_ONE;
        ovf_nx_s     = wr_en;
        udf_nx_s     = rd_en;
        if (clr_idx_r == {ADDR_W{1'b1}}) begin
          state_nx_s = IDLE;
          busy_nx_s  = 1'b0;
        end else begin
          state_nx_s = CLEAR;
          busy_nx_s  = 1'b1;
        end
      end
      default: begin
        state_nx_s = IDLE;
        busy_nx_s  = 1'b0;
      end
    endcase
  end

  // State, pointers and registered status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      clr_idx_r <= '0;
      count_r   <= '0;
      full_r    <= 1'b0;
      empty_r   <= 1'b1;
      busy_r    <= 1'b0;
      ovf_r     <= 1'b0;
      udf_r     <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      wr_ptr_r  <= wr_ptr_nx_s;
      rd_ptr_r  <= rd_ptr_nx_s;
      clr_idx_r <= clr_idx_nx_s;
      count_r   <= count_nx_s;
      full_r    <= (count_nx_s == CNT_FULL);
      empty_r   <= (count_nx_s == '0);
      busy_r    <= busy_nx_s;
      ovf_r     <= ovf_nx_s;
      udf_r     <= udf_nx_s;
    end
  end

  // Write enables are combinational, so gate them off while reset is held
  assign we      = reset_n ? we_s : '0;
  assign wdata   = wdata_s;
  assign rd_addr = rd_ptr_r;
  assign count   = count_r;
  assign full    = full_r;
  assign empty   = empty_r;
  assign busy    = busy_r;
  assign ovf     = ovf_r;
  assign udf     = udf_r;

endmodule

// File: tb/tb_fifo_out_write_ctrl.sv
// Randomized bench for fifo_out_write_ctrl: a queue-based FIFO model plus a local
// 32x32 register file driven by we/wdata so the head data can be checked.
module tb_fifo_out_write_ctrl;

  logic        clk;
  logic        reset_n;
  logic        wr_en;
  logic [31:0] din;
  logic        rd_en;
  logic        clear;
  logic [31:0] we;
  logic [31:0] wdata;
  logic [4:0]  rd_addr;
  logic [5:0]  count;
  logic        full, empty, busy, ovf, udf;

  fifo_out_write_ctrl #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .clear(clear), .we(we), .wdata(wdata), .rd_addr(rd_addr), .count(count),
    .full(full), .empty(empty), .busy(busy), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  logic [31:0] rf [32];
  int unsigned q[$];
  int          wp, rp, sweep_left;
  logic        exp_ovf, exp_udf;
  int          n_checks, n_errors;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_regs();
    check_eq("count", count, q.size());
    check_eq("full", full, q.size() == 32);
    check_eq("empty", empty, q.size() == 0);
    check_eq("busy", busy, sweep_left > 0);
    check_eq("ovf", ovf, exp_ovf);
    check_eq("udf", udf, exp_udf);
    check_eq("rd_addr", rd_addr, rp);
  endtask

  task automatic model_reset();
    q.delete();
    wp = 0; rp = 0; sweep_left = 0;
    exp_ovf = 1'b0; exp_udf = 1'b0;
  endtask

  // called at a negedge; holds requests high during reset to prove we stays 0
  task automatic do_reset();
    reset_n = 1'b0; wr_en = 1'b1; rd_en = 1'b1; clear = 1'b0; din = $urandom;
    #1;
    model_reset();
    check_eq("rst_we", we, 32'h0);
    check_regs();
    @(posedge clk);
    #1 check_eq("rst_we_hold", we, 32'h0);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; reset_n = 1'b1;
  endtask

  // one clock cycle: drive at negedge, check comb outputs, edge, check registered outputs
  task automatic step(input logic w, input logic r, input logic c, input logic [31:0] d);
    logic busy_m, full_m, empty_m, push_ok, pop_ok;
    logic [31:0] exp_we, cap_we, cap_wd;
    wr_en = w; rd_en = r; clear = c; din = d;
    #2;
    busy_m  = sweep_left > 0;
    full_m  = q.size() == 32;
    empty_m = q.size() == 0;
    push_ok = w && !full_m && !busy_m && !c;
    pop_ok  = r && !empty_m && !busy_m && !c;
    if (busy_m) exp_we = 32'h1 << (32 - sweep_left);
    else        exp_we = push_ok ? (32'h1 << wp) : 32'h0;
    check_eq("we", we, exp_we);
    if (exp_we != 32'h0) check_eq("wdata", wdata, busy_m ? 32'h0 : d);
    if (!busy_m && !empty_m) check_eq("head", rf[rd_addr], q[0]);
    cap_we = we; cap_wd = wdata;
    @(posedge clk);
    for (int i = 0; i < 32; i++) if (cap_we[i]) rf[i] = cap_wd;
    if (busy_m) begin
      sweep_left--;
      exp_ovf = w; exp_udf = r;
    end else if (c) begin
      q.delete();
      wp = 0; rp = 0; sweep_left = 32;
      exp_ovf = 1'b0; exp_udf = 1'b0;
    end else begin
      exp_ovf = w && full_m;
      exp_udf = r && empty_m;
      if (pop_ok) begin void'(q.pop_front()); rp = (rp + 1) % 32; end
      if (push_ok) begin q.push_back(d); wp = (wp + 1) % 32; end
    end
    #1 check_regs();
    @(negedge clk);
  endtask

  initial begin
    int nz;
    int mode;
    logic w, r, c;
    clk = 1'b0; reset_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0; din = 32'h0;
    n_checks = 0; n_errors = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    model_reset();
    @(negedge clk);
    do_reset();

    // three pushes then three pops
    for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, 1'b0, 32'hA5A5_0000 + i);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    // pop on empty -> underflow
    step(1'b0, 1'b1, 1'b0, 32'h0);
    // fill to full, 33rd push overflows
    for (int i = 0; i < 33; i++) step(1'b1, 1'b0, 1'b0, $urandom);
    // wrap: two pops, two pushes
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, $urandom);
    // push+pop while full, then drain and push+pop while empty
    step(1'b1, 1'b1, 1'b0, $urandom);
    for (int i = 0; i < 31; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, $urandom);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    // clear at count 10 with a push in the same cycle, full sweep with requests
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, $urandom);
    step(1'b1, 1'b0, 1'b1, $urandom);
    for (int i = 0; i < 32; i++) step(i[0], i[1], i[2], $urandom);
    nz = 0;
    for (int i = 0; i < 32; i++) if (rf[i] != 32'h0) nz++;
    check_eq("sweep_zero", nz, 0);
    step(1'b1, 1'b0, 1'b0, $urandom);
    // reset during a sweep
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, $urandom);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    do_reset();
    step(1'b1, 1'b0, 1'b0, 32'h1234_5678);

    // randomized traffic with fill/drain/balanced phases
    for (int n = 0; n < 3000; n++) begin
      mode = (n / 200) % 3;
      case (mode)
        0:       begin w = ($urandom_range(0, 9) < 8); r = ($urandom_range(0, 9) < 2); end
        1:       begin w = ($urandom_range(0, 9) < 2); r = ($urandom_range(0, 9) < 8); end
        default: begin w = $urandom_range(0, 1); r = $urandom_range(0, 1); end
      endcase
      c = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 699) == 0) do_reset();
      else step(w, r, c, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
